// File: rtl/dm_responder.sv
// dm_responder: a data-memory responder on the CPU load/store port.
// It accepts one request per valid/ready handshake, waits WAIT_CYC cycles,
// and then holds the response until the CPU takes it. Only one request is
// outstanding at a time.
//
// Optional feature, controlled by the DM_TRACE_EN macro:
//   defined   - prints a trace line for every committed store
//   undefined - no trace output
//
// Ports:
//   clk, rst          clock (rising edge); reset is asynchronous, active-low
//   req_valid/ready   request handshake (ready is high only in IDLE)
//   req_we/addr/be    store flag, byte address, byte enables
//   req_wdata/pc      store data (lanes already aligned), PC for the trace
//   rsp_valid/ready   response handshake
//   rsp_rdata/err     load data, and an out-of-range flag
//
// Timing: a request accepted at edge t gives rsp_valid high after edge
// t+1+WAIT_CYC. The counter is therefore loaded with WAIT_CYC on accept.
// Every request passes through WAIT, so WAIT_CYC=0 still gives one cycle
// of latency.
module dm_responder #(
  parameter int AW       = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]   mem [1<<AW];
  logic          accept, commit, addr_err, wr_en;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, merged;

  // Address bits 1:0 are not used for addressing. The PC is only used by the trace.
  logic unused_bits;
  assign unused_bits = ^{pc_q, addr_q[1:0]};

  assign accept   = (state_q == S_IDLE) && req_valid;
  // The last WAIT cycle is the edge that enters RESP. That edge is where
  // the store is written and the load data is captured.
  assign commit   = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign idx      = addr_q[AW+1:2];
  assign addr_err = |addr_q[31:AW+2];
  assign rd_word  = mem[idx];
  assign wr_en    = commit && we_q && !addr_err && (|be_q);

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++)
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_WAIT;
        cnt_d   = 4'(WAIT_CYC);
        we_d    = req_we;
        addr_d  = req_addr;
        be_d    = req_be;
        wdata_d = req_wdata;
        pc_d    = req_pc;
      end
      S_WAIT: if (commit) begin
        state_d = S_RESP;
        err_d   = addr_err;
        rdata_d = (!we_q && !addr_err) ? rd_word : 32'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP: if (rsp_ready) begin
        state_d = S_IDLE;
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  // The storage array is never cleared. A reset during WAIT drops the
  // state back to IDLE before commit, so a pending store is never written.
  always_ff @(posedge clk)
    if (wr_en) mem[idx] <= merged;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk)
    if (wr_en)
      $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, merged);
`else
`endif

endmodule
